// File: rtl/cpl_tx_engine.sv
// Completion transmit engine: serializes Cpl/CplD TLPs onto the 32-bit TRN TX interface.
// Optional TX_STALL_CNT_EN macro adds stall_cnt_o, a saturating count of back-pressured cycles.
module cpl_tx_engine #(
  parameter int MAX_LEN     = 16,
  parameter int CPL_BUF_MIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef TX_STALL_CNT_EN
  output logic [15:0] stall_cnt_o,
`endif
  input  logic        req_compl_i,
  input  logic        req_compl_with_data_i,
  output logic        compl_done_o,
  output logic        busy_o,
  input  logic [2:0]  req_tc_i,
  input  logic        req_td_i,
  input  logic        req_ep_i,
  input  logic [1:0]  req_attr_i,
  input  logic [9:0]  req_len_i,
  input  logic [15:0] req_rid_i,
  input  logic [7:0]  req_tag_i,
  input  logic [7:0]  req_be_i,
  input  logic [12:0] req_addr_i,
  input  logic [15:0] cfg_completer_id_i,
  output logic [10:0] rd_addr_o,
  output logic [3:0]  rd_be_o,
  input  logic [31:0] rd_data_i,
  output logic [31:0] trn_td_o,
  output logic        trn_tsof_n_o,
  output logic        trn_teof_n_o,
  output logic        trn_tsrc_rdy_n_o,
  output logic        trn_tsrc_dsc_n_o,
  input  logic        trn_tdst_rdy_n_i,
  input  logic        trn_tdst_dsc_n_i,
  input  logic [5:0]  trn_tbuf_av_i
);

  // Handshake: a beat transfers on any cycle with trn_tsrc_rdy_n_o=0 and trn_tdst_rdy_n_i=0;
  // data and framing are pure functions of state, so they hold until that cycle.
  typedef enum logic [2:0] {S_IDLE, S_WAIT_BUF, S_H0, S_H1, S_H2, S_DATA, S_DONE} state_t;
  state_t state, state_nxt;

  logic        is_data;
  logic [2:0]  tc;
  logic        td, ep;
  logic [1:0]  attr;
  logic [10:0] len_eff;
  logic [15:0] rid, cid;
  logic [7:0]  tag;
  logic [3:0]  first_be, last_be;
  logic [4:0]  addr_lo;
  logic [10:0] ptr, beat_cnt;

  logic        capture, src_active, accept, last_beat;
  logic [10:0] len_req, len_cap;
  logic [1:0]  tz_first, lz_last;
  logic [2:0]  bc_one;
  logic [11:0] byte_cnt;
  logic [31:0] hdr0, hdr1, hdr2;
  logic        unused_ok;

  assign unused_ok  = &{1'b0, req_addr_i[1:0]};
  assign capture    = (state == S_IDLE) && (req_compl_i || req_compl_with_data_i);
  assign len_req    = (req_len_i == 10'd0) ? 11'd1024 : {1'b0, req_len_i};
  assign len_cap    = (len_req > 11'(MAX_LEN)) ? 11'(MAX_LEN) : len_req;
  assign src_active = (state == S_H0) || (state == S_H1) || (state == S_H2) || (state == S_DATA);
  assign accept     = src_active && !trn_tdst_rdy_n_i;
  assign last_beat  = (beat_cnt == len_eff - 11'd1);

  always_comb begin
    tz_first = 2'd0;
    lz_last  = 2'd0;
    bc_one   = 3'd1;
    casez (first_be)
      4'b???1: tz_first = 2'd0;
      4'b??10: tz_first = 2'd1;
      4'b?100: tz_first = 2'd2;
      4'b1000: tz_first = 2'd3;
      default: tz_first = 2'd0;
    endcase
    casez (last_be)
      4'b1???: lz_last = 2'd0;
      4'b01??: lz_last = 2'd1;
      4'b001?: lz_last = 2'd2;
      4'b0001: lz_last = 2'd3;
      default: lz_last = 2'd0;
    endcase
    casez (first_be)
      4'b1??1:                   bc_one = 3'd4;
      4'b01?1, 4'b1?10:          bc_one = 3'd3;
      4'b0011, 4'b0110, 4'b1100: bc_one = 3'd2;
      default:                   bc_one = 3'd1;
    endcase
  end

  // A 1024-DW byte count wraps to 0 in the 12-bit field, which is the wire encoding.
  assign byte_cnt = !is_data ? 12'd4 :
                    (len_eff == 11'd1) ? {9'd0, bc_one} :
                    {len_eff[9:0], 2'b00} - {10'd0, tz_first} - {10'd0, lz_last};

  assign hdr0 = {1'b0, is_data, 1'b0, 5'b01010, 1'b0, tc, 4'b0000, td, ep, attr, 2'b00,
                 is_data ? len_eff[9:0] : 10'd0};
  assign hdr1 = {cid, 3'b000, 1'b0, byte_cnt};
  assign hdr2 = {rid, tag, 1'b0, addr_lo, tz_first};

  assign rd_addr_o        = (state == S_DATA && accept) ? ptr + 11'd1 : ptr;
  assign rd_be_o          = (state == S_H2 || state == S_DATA) ? 4'hF : 4'h0;
  assign busy_o           = (state != S_IDLE);
  assign trn_tsrc_rdy_n_o = !src_active;
  assign trn_tsrc_dsc_n_o = 1'b1;

  always_comb begin
    state_nxt    = state;
    trn_td_o     = 32'd0;
    trn_tsof_n_o = 1'b1;
    trn_teof_n_o = 1'b1;
    compl_done_o = 1'b0;
    case (state)
      S_IDLE:     if (capture) state_nxt = S_WAIT_BUF;
      S_WAIT_BUF: if ({26'd0, trn_tbuf_av_i} >= 32'(CPL_BUF_MIN)) state_nxt = S_H0;
      S_H0: begin
        trn_td_o     = hdr0;
        trn_tsof_n_o = 1'b0;
        if (!trn_tdst_dsc_n_i) state_nxt = S_DONE;
        else if (accept)       state_nxt = S_H1;
      end
      S_H1: begin
        trn_td_o = hdr1;
        if (!trn_tdst_dsc_n_i) state_nxt = S_DONE;
        else if (accept)       state_nxt = S_H2;
      end
      S_H2: begin
        trn_td_o     = hdr2;
        trn_teof_n_o = is_data;
        if (!trn_tdst_dsc_n_i) state_nxt = S_DONE;
        else if (accept)       state_nxt = is_data ? S_DATA : S_DONE;
      end
      S_DATA: begin
        // Memory output already tracks the current pointer, so it feeds the bus directly.
        trn_td_o     = rd_data_i;
        trn_teof_n_o = !last_beat;
        if (!trn_tdst_dsc_n_i)       state_nxt = S_DONE;
        else if (accept && last_beat) state_nxt = S_DONE;
      end
      S_DONE: begin
        compl_done_o = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      is_data  <= 1'b0;
      tc       <= 3'd0;
      td       <= 1'b0;
      ep       <= 1'b0;
      attr     <= 2'd0;
      len_eff  <= 11'd0;
      rid      <= 16'd0;
      cid      <= 16'd0;
      tag      <= 8'd0;
      first_be <= 4'd0;
      last_be  <= 4'd0;
      addr_lo  <= 5'd0;
      ptr      <= 11'd0;
      beat_cnt <= 11'd0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        is_data  <= req_compl_with_data_i;
        tc       <= req_tc_i;
        td       <= req_td_i;
        ep       <= req_ep_i;
        attr     <= req_attr_i;
        len_eff  <= len_cap;
        rid      <= req_rid_i;
        cid      <= cfg_completer_id_i;
        tag      <= req_tag_i;
        first_be <= req_be_i[3:0];
        last_be  <= req_be_i[7:4];
        addr_lo  <= req_addr_i[6:2];
        ptr      <= req_addr_i[12:2];
        beat_cnt <= 11'd0;
      end else if (state == S_DATA && accept) begin
        ptr      <= ptr + 11'd1;
        beat_cnt <= beat_cnt + 11'd1;
      end
    end
  end

`ifdef TX_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt_o <= 16'd0;
    else if (src_active && trn_tdst_rdy_n_i && stall_cnt_o != 16'hFFFF)
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule
